// File: rtl/ex_mc_scheduler.sv
// -----------------------------------------------------------------------------
// ex_mc_scheduler
//
// Sequences the multi-cycle functional units (multiplier, divider, FPU) that
// share the single EX/MEM result slot with the single-cycle ALU. One
// instruction per cycle arrives from ID/EX. A multi-cycle op is launched with a
// one-cycle start pulse and then counted down. Younger instructions are held
// off until the result has been handed to EX/MEM. The EX/MEM result mux is
// steered from here, and the in-flight destination is exported to the hazard
// unit.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   issue_valid  valid instruction in ID/EX this cycle
//   issue_unit   00 ALU, 01 MUL, 10 DIV, 11 FPU
//   issue_rd     destination register of the issuing instruction
//   issue_wb     issuing instruction writes back
//   flush        registered branch/jump flush from EX/MEM
//   mem_stall    MEM cannot accept a result this cycle
//   ex_stall     hold ID/EX and earlier stages (combinational)
//   mc_start     one-cycle launch pulse to the selected unit
//   mc_unit      unit code of the in-flight op (00 when idle)
//   res_sel      EX/MEM result mux: 0 = ALU, 1 = multi-cycle unit (comb.)
//   res_valid    multi-cycle result presented to EX/MEM (comb.)
//   res_rd       destination of the in-flight/completing op
//   res_wb       writeback enable of the completing op
//   busy         a multi-cycle op is in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module ex_mc_scheduler #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int FPU_LAT = 5,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [1:0] issue_unit,
    input  logic [4:0] issue_rd,
    input  logic       issue_wb,
    input  logic       flush,
    input  logic       mem_stall,
    output logic       ex_stall,
    output logic       mc_start,
    output logic [1:0] mc_unit,
    output logic       res_sel,
    output logic       res_valid,
    output logic [4:0] res_rd,
    output logic       res_wb,
    output logic       busy
);

    localparam logic [1:0] UNIT_ALU = 2'b00;
    localparam logic [1:0] UNIT_MUL = 2'b01;
    localparam logic [1:0] UNIT_DIV = 2'b10;
    localparam logic [1:0] UNIT_FPU = 2'b11;

    // Countdown preloads: the op spends LAT cycles in RUN, the last of which
    // sees cnt == 0.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] FPU_CNT = CNT_W'(FPU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state,    state_nx;
    logic [CNT_W-1:0] cnt,      cnt_nx;
    logic             first,    first_nx;
    logic [1:0]       cap_unit, cap_unit_nx;
    logic [4:0]       cap_rd,   cap_rd_nx;
    logic             cap_wb,   cap_wb_nx;

    logic accept;

    function automatic logic [CNT_W-1:0] lat_cnt(input logic [1:0] unit);
        case (unit)
            UNIT_MUL: lat_cnt = MUL_CNT;
            UNIT_DIV: lat_cnt = DIV_CNT;
            UNIT_FPU: lat_cnt = FPU_CNT;
            default:  lat_cnt = '0;
        endcase
    endfunction

    // Flush beats a simultaneous multi-cycle issue; ALU ops never enter the FSM.
    assign accept = (state == S_IDLE) && issue_valid && (issue_unit != UNIT_ALU) && !flush;

    // -------------------------------------------------------------------------
    // Next-state / next-datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_nx    = state;
        cnt_nx      = cnt;
        first_nx    = 1'b0;     // first is only ever high for one RUN cycle
        cap_unit_nx = cap_unit;
        cap_rd_nx   = cap_rd;
        cap_wb_nx   = cap_wb;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx    = S_RUN;
                    cnt_nx      = lat_cnt(issue_unit);
                    first_nx    = 1'b1;
                    cap_unit_nx = issue_unit;
                    cap_rd_nx   = issue_rd;
                    cap_wb_nx   = issue_wb;
                end
            end

            S_RUN: begin
                if (flush && first) begin
                    // The op was issued in the shadow of the flushing branch:
                    // drop it before it can ever reach writeback. A flush seen
                    // later belongs to a younger branch and is ignored.
                    state_nx    = S_IDLE;
                    cnt_nx      = '0;
                    cap_unit_nx = UNIT_ALU;
                    cap_rd_nx   = '0;
                    cap_wb_nx   = 1'b0;
                end else if (cnt == '0) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            S_DONE: begin
                // Hold the result until MEM takes it.
                if (!mem_stall) begin
                    state_nx    = S_IDLE;
                    cnt_nx      = '0;
                    cap_unit_nx = UNIT_ALU;
                    cap_rd_nx   = '0;
                    cap_wb_nx   = 1'b0;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            first    <= 1'b0;
            cap_unit <= UNIT_ALU;
            cap_rd   <= '0;
            cap_wb   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state    <= state_nx;
            cnt      <= cnt_nx;
            first    <= first_nx;
            cap_unit <= cap_unit_nx;
            cap_rd   <= cap_rd_nx;
            cap_wb   <= cap_wb_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Decodes of registered state.
    assign busy     = (state != S_IDLE);
    assign mc_start = first;
    assign mc_unit  = busy ? cap_unit : UNIT_ALU;
    assign res_rd   = busy ? cap_rd : 5'd0;
    assign res_wb   = (state == S_DONE) && cap_wb;

    // Combinational with the inputs: anything behind an in-flight op waits,
    // ALU ops included, so results retire in order.
    assign ex_stall  = issue_valid && (state != S_IDLE);
    assign res_sel   = (state == S_DONE);
    assign res_valid = (state == S_DONE) && !mem_stall;

endmodule
